// File: rtl/aftab_csr_access_ctrl_if.sv
// CSR-file bus between the Zicsr sequencer (master) and the CSR file (slave).
// Carries the latched address, read/write strobes, write data and read data.
interface aftab_csr_access_ctrl_if #(
   parameter int DATA_W = 32
);
   logic [11:0]       csrAddrOut;
   logic              csrRdEn;
   logic              csrWrEn;
   logic [DATA_W-1:0] csrWrData;
   logic [DATA_W-1:0] csrRdData;

   modport master (
      output csrAddrOut,
      output csrRdEn,
      output csrWrEn,
      output csrWrData,
      input  csrRdData
   );

   modport slave (
      input  csrAddrOut,
      input  csrRdEn,
      input  csrWrEn,
      input  csrWrData,
      output csrRdData
   );
endinterface

// File: rtl/aftab_csr_access_ctrl.sv
// Zicsr sequencer: latch request, check legality, read/modify/write the CSR file.
// Ports: clk, rst (sync active-low), request inputs, nonExistingCSR, csrBus
// (CSR-file master), rdData/rdWrEn to the register file, busy/done/illegalCSR.
module aftab_csr_access_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              startCSR,
   input  logic [11:0]       CSR_AddrIn,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] operand,
   input  logic              rs1Zero,
   input  logic              rdZero,
   input  logic [1:0]        curPriv,
   input  logic              nonExistingCSR,
   aftab_csr_access_ctrl_if.master csrBus,
   output logic [DATA_W-1:0] rdData,
   output logic              rdWrEn,
   output logic              busy,
   output logic              done,
   output logic              illegalCSR
);

   typedef enum logic [2:0] {
      IDLE,
      CHECK,
      READ,
      WRITE,
      DONE,
      ILLEGAL
   } state_t;

   state_t            state;
   logic [2:0]        f3Q;
   logic [DATA_W-1:0] opQ;
   logic [DATA_W-1:0] oldQ;
   logic              rs1ZeroQ;
   logic              rdZeroQ;
   logic [1:0]        privQ;

   logic isRw;
   logic badF3;
   logic accWrites;
   logic accReads;
   logic accIllegal;

   // funct3[2] only selects rs1 vs uimm upstream; [1:0] picks the operation.
   assign isRw      = (f3Q[1:0] == 2'b01);
   assign badF3     = (f3Q[1:0] == 2'b00);
   assign accWrites = isRw | ~rs1ZeroQ;
   assign accReads  = ~(isRw & rdZeroQ);
   assign accIllegal = nonExistingCSR
                     | badF3
                     | (csrBus.csrAddrOut[9:8] > privQ)
                     | ((csrBus.csrAddrOut[11:10] == 2'b11) & accWrites);

   function automatic logic [DATA_W-1:0] modify(
      input logic [DATA_W-1:0] oldVal,
      input logic [DATA_W-1:0] opVal,
      input logic [1:0]        op
   );
      logic [DATA_W-1:0] r;
      r = opVal;
      unique case (1'b1)
         (op == 2'b10): r = oldVal | opVal;
         (op == 2'b11): r = oldVal & ~opVal;
         default:       r = opVal;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state             <= IDLE;
         f3Q               <= '0;
         opQ               <= '0;
         oldQ              <= '0;
         rs1ZeroQ          <= 1'b0;
         rdZeroQ           <= 1'b0;
         privQ             <= '0;
         csrBus.csrAddrOut <= '0;
         csrBus.csrRdEn    <= 1'b0;
         csrBus.csrWrEn    <= 1'b0;
         csrBus.csrWrData  <= '0;
         rdData            <= '0;
         rdWrEn            <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         illegalCSR        <= 1'b0;
      end else begin
         // Strobes are set only on entry to their state, so each lasts one cycle.
         csrBus.csrRdEn <= 1'b0;
         csrBus.csrWrEn <= 1'b0;
         rdWrEn         <= 1'b0;
         done           <= 1'b0;
         illegalCSR     <= 1'b0;
         unique case (state)
            IDLE: begin
               if (startCSR) begin
                  csrBus.csrAddrOut <= CSR_AddrIn;
                  f3Q      <= funct3;
                  opQ      <= operand;
                  rs1ZeroQ <= rs1Zero;
                  rdZeroQ  <= rdZero;
                  privQ    <= curPriv;
                  oldQ     <= '0;
                  busy     <= 1'b1;
                  state    <= CHECK;
               end
            end
            CHECK: begin
               if (accIllegal) begin
                  illegalCSR <= 1'b1;
                  state      <= ILLEGAL;
               end else if (accReads) begin
                  csrBus.csrRdEn <= 1'b1;
                  state          <= READ;
               end else begin
                  csrBus.csrWrEn   <= 1'b1;
                  csrBus.csrWrData <= modify('0, opQ, f3Q[1:0]);
                  state            <= WRITE;
               end
            end
            READ: begin
               // Read data is only valid now, so use it directly for the next state.
               oldQ <= csrBus.csrRdData;
               if (accWrites) begin
                  csrBus.csrWrEn   <= 1'b1;
                  csrBus.csrWrData <= modify(csrBus.csrRdData, opQ, f3Q[1:0]);
                  state            <= WRITE;
               end else begin
                  done   <= 1'b1;
                  rdWrEn <= ~rdZeroQ;
                  rdData <= csrBus.csrRdData;
                  state  <= DONE;
               end
            end
            WRITE: begin
               done   <= 1'b1;
               rdWrEn <= ~rdZeroQ;
               rdData <= oldQ;
               state  <= DONE;
            end
            DONE, ILLEGAL: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aftab_csr_access_ctrl.sv
// Directed table-driven bench for aftab_csr_access_ctrl.
// Models a small CSR file and the non-existing-CSR checker.
module tb_aftab_csr_access_ctrl;

   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              startCSR;
   logic [11:0]       CSR_AddrIn;
   logic [2:0]        funct3;
   logic [DATA_W-1:0] operand;
   logic              rs1Zero;
   logic              rdZero;
   logic [1:0]        curPriv;
   logic              nonExistingCSR;
   logic [DATA_W-1:0] rdData;
   logic              rdWrEn;
   logic              busy;
   logic              done;
   logic              illegalCSR;

   aftab_csr_access_ctrl_if #(.DATA_W(DATA_W)) bus ();

   aftab_csr_access_ctrl #(.DATA_W(DATA_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .startCSR       (startCSR),
      .CSR_AddrIn     (CSR_AddrIn),
      .funct3         (funct3),
      .operand        (operand),
      .rs1Zero        (rs1Zero),
      .rdZero         (rdZero),
      .curPriv        (curPriv),
      .nonExistingCSR (nonExistingCSR),
      .csrBus         (bus.master),
      .rdData         (rdData),
      .rdWrEn         (rdWrEn),
      .busy           (busy),
      .done           (done),
      .illegalCSR     (illegalCSR)
   );

   always #5 clk = ~clk;

   function automatic logic exists(input logic [11:0] a);
      return (a == 12'h300) || (a == 12'h304) || (a == 12'h344) ||
             (a == 12'h305) || (a == 12'hC00) || (a == 12'h105);
   endfunction

   function automatic logic [31:0] csrVal(input logic [11:0] a);
      logic [31:0] v;
      v = 32'h0;
      case (a)
         12'h300: v = 32'h0000_1800;
         12'h304: v = 32'h0000_AAAA;
         12'h344: v = 32'h0000_00FF;
         12'h305: v = 32'h0000_0100;
         12'hC00: v = 32'h0000_1234;
         12'h105: v = 32'h0000_0040;
         default: v = 32'h0;
      endcase
      return v;
   endfunction

   assign nonExistingCSR = ~exists(bus.csrAddrOut);
   assign bus.csrRdData  = bus.csrRdEn ? csrVal(bus.csrAddrOut) : 32'hDEAD_BEEF;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [11:0] addr;
      logic [2:0]  f3;
      logic [31:0] op;
      logic        rs1Z;
      logic        rdZ;
      logic [1:0]  priv;
      int          eIll;
      int          eRd;
      int          eWr;
      logic [31:0] eWrData;
      int          eDone;
      int          eRdWr;
      logic [31:0] eRdData;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs[NV];

   task automatic runVec(input vec_t v, input int idx);
      int illCyc, illCnt, rdCyc, wrCyc, wrCnt, doneCyc, doneCnt, rdWrCnt;
      logic [31:0] wrD, rdD;
      logic busy1, busyEnd;
      string tag;
      illCyc = 0; illCnt = 0; rdCyc = 0; wrCyc = 0; wrCnt = 0;
      doneCyc = 0; doneCnt = 0; rdWrCnt = 0;
      wrD = '0; rdD = '0; busy1 = 1'b0; busyEnd = 1'b1;
      @(negedge clk);
      CSR_AddrIn = v.addr; funct3 = v.f3; operand = v.op;
      rs1Zero = v.rs1Z; rdZero = v.rdZ; curPriv = v.priv;
      startCSR = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         startCSR = 1'b0;
         if (k == 1) busy1 = busy;
         if (k == 8) busyEnd = busy;
         if (illegalCSR) begin
            if (illCyc == 0) illCyc = k;
            illCnt++;
         end
         if (bus.csrRdEn && rdCyc == 0) rdCyc = k;
         if (bus.csrWrEn) begin
            if (wrCyc == 0) begin wrCyc = k; wrD = bus.csrWrData; end
            wrCnt++;
         end
         if (done) begin
            if (doneCyc == 0) begin doneCyc = k; rdD = rdData; end
            doneCnt++;
         end
         if (rdWrEn) rdWrCnt++;
      end
      tag = $sformatf("v%0d", idx);
      check({tag, " illCyc"},  32'(illCyc),  32'(v.eIll));
      check({tag, " illCnt"},  32'(illCnt),  32'(v.eIll != 0));
      check({tag, " rdCyc"},   32'(rdCyc),   32'(v.eRd));
      check({tag, " wrCyc"},   32'(wrCyc),   32'(v.eWr));
      check({tag, " wrCnt"},   32'(wrCnt),   32'(v.eWr != 0));
      if (v.eWr != 0) check({tag, " wrData"}, wrD, v.eWrData);
      check({tag, " doneCyc"}, 32'(doneCyc), 32'(v.eDone));
      check({tag, " doneCnt"}, 32'(doneCnt), 32'(v.eDone != 0));
      check({tag, " rdWrCnt"}, 32'(rdWrCnt), 32'(v.eRdWr));
      if (v.eDone != 0) check({tag, " rdData"}, rdD, v.eRdData);
      check({tag, " busy1"},   32'(busy1),   32'd1);
      check({tag, " busyEnd"}, 32'(busyEnd), 32'd0);
      check({tag, " addr"},    32'(bus.csrAddrOut), 32'(v.addr));
   endtask

   initial begin
      int wrCnt, doneCnt, rdWrCnt;
      //            addr    f3    op            rs1Z rdZ priv ill rd wr wrData        done rdWr rdData
      vecs[0]  = '{12'h340, 3'b001, 32'h5,        0, 0, 3, 2, 0, 0, 32'h0,         0, 0, 32'h0};
      vecs[1]  = '{12'h300, 3'b001, 32'h88,       0, 0, 3, 0, 2, 3, 32'h88,        4, 1, 32'h1800};
      vecs[2]  = '{12'h304, 3'b010, 32'h0,        1, 0, 3, 0, 2, 0, 32'h0,         3, 1, 32'hAAAA};
      vecs[3]  = '{12'h344, 3'b011, 32'h0F,       0, 0, 3, 0, 2, 3, 32'hF0,        4, 1, 32'hFF};
      vecs[4]  = '{12'h300, 3'b001, 32'h1,        0, 0, 0, 2, 0, 0, 32'h0,         0, 0, 32'h0};
      vecs[5]  = '{12'hC00, 3'b001, 32'h1,        0, 0, 3, 2, 0, 0, 32'h0,         0, 0, 32'h0};
      vecs[6]  = '{12'hC00, 3'b010, 32'h0,        1, 0, 3, 0, 2, 0, 32'h0,         3, 1, 32'h1234};
      vecs[7]  = '{12'h305, 3'b101, 32'h1F,       0, 1, 3, 0, 0, 2, 32'h1F,        3, 0, 32'h0};
      vecs[8]  = '{12'h300, 3'b110, 32'h6,        0, 0, 3, 0, 2, 3, 32'h1806,      4, 1, 32'h1800};
      vecs[9]  = '{12'h300, 3'b000, 32'h1,        0, 0, 3, 2, 0, 0, 32'h0,         0, 0, 32'h0};
      vecs[10] = '{12'h300, 3'b100, 32'h1,        0, 0, 3, 2, 0, 0, 32'h0,         0, 0, 32'h0};
      vecs[11] = '{12'h300, 3'b111, 32'h800,      0, 0, 1, 2, 0, 0, 32'h0,         0, 0, 32'h0};
      vecs[12] = '{12'h304, 3'b011, 32'h0A,       0, 1, 3, 0, 2, 3, 32'hAAA0,      4, 0, 32'hAAAA};
      vecs[13] = '{12'h105, 3'b010, 32'h0,        1, 0, 1, 0, 2, 0, 32'h0,         3, 1, 32'h40};

      rst = 1'b0; startCSR = 1'b0; CSR_AddrIn = '0; funct3 = '0;
      operand = '0; rs1Zero = 1'b0; rdZero = 1'b0; curPriv = 2'b11;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst busy",  32'(busy), 32'd0);
      check("rst done",  32'(done), 32'd0);
      check("rst ill",   32'(illegalCSR), 32'd0);
      check("rst addr",  32'(bus.csrAddrOut), 32'd0);
      check("rst rdata", rdData, 32'd0);
      check("rst wrdat", bus.csrWrData, 32'd0);
      rst = 1'b1;

      for (int i = 0; i < NV; i++) runVec(vecs[i], i);

      // Reset while in READ aborts the access.
      @(negedge clk);
      CSR_AddrIn = 12'h300; funct3 = 3'b001; operand = 32'h88;
      rs1Zero = 1'b0; rdZero = 1'b0; curPriv = 2'b11; startCSR = 1'b1;
      @(negedge clk);
      startCSR = 1'b0;
      @(negedge clk);
      check("abort inRead", 32'(bus.csrRdEn), 32'd1);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("abort busy",  32'(busy), 32'd0);
      check("abort rdEn",  32'(bus.csrRdEn), 32'd0);
      check("abort wrEn",  32'(bus.csrWrEn), 32'd0);
      check("abort addr",  32'(bus.csrAddrOut), 32'd0);
      wrCnt = 0; doneCnt = 0; rdWrCnt = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         wrCnt   += int'(bus.csrWrEn);
         doneCnt += int'(done);
         rdWrCnt += int'(rdWrEn);
      end
      check("abort noWr",   32'(wrCnt), 32'd0);
      check("abort noDone", 32'(doneCnt), 32'd0);
      check("abort noRdWr", 32'(rdWrCnt), 32'd0);

      // startCSR while busy is ignored and not queued.
      @(negedge clk);
      CSR_AddrIn = 12'h304; funct3 = 3'b010; operand = 32'h0;
      rs1Zero = 1'b1; rdZero = 1'b0; curPriv = 2'b11; startCSR = 1'b1;
      doneCnt = 0; wrCnt = 0;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         startCSR   = (k <= 2);
         CSR_AddrIn = 12'h300;
         funct3     = 3'b001;
         operand    = 32'h77;
         rs1Zero    = 1'b0;
         doneCnt += int'(done);
         wrCnt   += int'(bus.csrWrEn);
      end
      startCSR = 1'b0;
      check("busyStart dones", 32'(doneCnt), 32'd1);
      check("busyStart noWr",  32'(wrCnt), 32'd0);
      check("busyStart addr",  32'(bus.csrAddrOut), 32'h304);
      check("busyStart rdata", rdData, 32'hAAAA);
      check("busyStart idle",  32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
